wb_stage: RTL

//  Writeback stage of the five-stage pipeline: MEM/WB pipeline register plus writeback control.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_load_align.sv | 29 ++
 rtl/wb_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: FSM states, load-size codes, held-instruction fields.
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_LD = 2'd1,
    COMMIT  = 2'd2
  } wb_state_e;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] ld_size;
    logic       ld_unsigned;
    logic [1:0] offset;
  } wb_hold_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: selects byte/half/word from the read word and extends it to N bits.
module load_align
  import wb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] ld_data,
  input  logic [1:0]   offset,
  input  logic [1:0]   size,
  input  logic         uns,
  output logic [N-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = ld_data[{offset, 3'b000} +: 8];
  assign half_sel = ld_data[{offset[1], 4'b0000} +: 16];

  always_comb begin
    value = ld_data;
    case (size)
      LD_BYTE: value = uns ? {{(N-8){1'b0}}, byte_sel}  : {{(N-8){byte_sel[7]}}, byte_sel};
      LD_HALF: value = uns ? {{(N-16){1'b0}}, half_sel} : {{(N-16){half_sel[15]}}, half_sel};
      default: value = ld_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, late-load wait, one-cycle register file commit, retire counter.
// Optional WB_FWD_EN drives the same-cycle bypass to decode; otherwise fwd_* are tied to 0.
module wb_stage
  import wb_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_to_reg,
  input  logic [N-1:0]     mem_alu_result,
  input  logic [1:0]       mem_ld_size,
  input  logic             mem_ld_unsigned,
  input  logic             ld_valid,
  input  logic [N-1:0]     ld_data,
  input  logic             wb_flush,
  output logic [4:0]       rf_rd,
  output logic             rf_write,
  output logic [N-1:0]     rf_wdata,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [N-1:0]     fwd_data
);

  wb_state_e      state, state_nxt;
  wb_hold_t       hold;
  logic           xfer, waiting;
  logic [N-1:0]   ld_aligned;
  logic [4:0]     wr_rd;
  logic           wr_rw;
  logic [N-1:0]   wr_data;

  assign waiting   = (state == WAIT_LD);
  assign mem_ready = ~waiting;
  assign xfer      = mem_valid & mem_ready & ~wb_flush;

  // One aligner serves both the same-cycle path and the late-load path.
  load_align #(.N(N)) u_align (
    .ld_data (ld_data),
    .offset  (waiting ? hold.offset      : mem_alu_result[1:0]),
    .size    (waiting ? hold.ld_size     : mem_ld_size),
    .uns     (waiting ? hold.ld_unsigned : mem_ld_unsigned),
    .value   (ld_aligned)
  );

  always_comb begin
    state_nxt = EMPTY;
    wr_rd     = mem_rd;
    wr_rw     = mem_reg_write;
    wr_data   = mem_to_reg ? ld_aligned : mem_alu_result;
    case (state)
      WAIT_LD: begin
        wr_rd   = hold.rd;
        wr_rw   = hold.reg_write;
        wr_data = ld_aligned;
        if (wb_flush)      state_nxt = EMPTY;
        else if (ld_valid) state_nxt = COMMIT;
        else               state_nxt = WAIT_LD;
      end
      default: begin
        if (xfer) state_nxt = (mem_to_reg & ~ld_valid) ? WAIT_LD : COMMIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      hold        <= '0;
      rf_rd       <= '0;
      rf_write    <= 1'b0;
      rf_wdata    <= '0;
      retired_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rf_write <= (state_nxt == COMMIT) & wr_rw;
      if (xfer)
        hold <= '{rd: mem_rd, reg_write: mem_reg_write, ld_size: mem_ld_size,
                  ld_unsigned: mem_ld_unsigned, offset: mem_alu_result[1:0]};
      if (state_nxt == COMMIT) begin
        rf_rd       <= wr_rd;
        rf_wdata    <= wr_data;
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

`ifdef WB_FWD_EN
  // rf_write is high exactly in COMMIT with reg_write set.
  assign fwd_valid = rf_write;
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule
